// File: rtl/platypus_pkg.sv
// Shared definitions for the DAQ scan controller: scan FSM states and the
// default values of the block parameters.
package platypus_pkg;

    localparam int NUM_CHIPS_DEF    = 8;
    localparam int CH_PER_CHIP_DEF  = 8;
    localparam int RD_CYC_DEF       = 2;
    localparam int CONV_LOW_CYC_DEF = 4;
    localparam int BUSY_TO_DEF      = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONV    = 3'd1,
        ST_WAIT_BH = 3'd2,
        ST_WAIT_BL = 3'd3,
        ST_RD_LO   = 3'd4,
        ST_RD_HI   = 3'd5,
        ST_PUSH    = 3'd6
    } state_e;

endpackage

// File: rtl/daq_period_tick.sv
// Free-running conversion period counter. Counts 0..period_i and pulses
// tick_o in the wrap cycle; held at 0 while disabled.
module daq_period_tick (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [15:0] period_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;

    // >= so that shrinking period_i mid-count wraps immediately instead of
    // running all the way round the 16-bit range.
    assign tick_o = en_i && (cnt_q >= period_i);

    // Next count: clear when disabled or wrapping, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!en_i || tick_o) cnt_d = 16'd0;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= 16'd0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/daq_scan_ctrl.sv
// Multi-chip parallel ADC scan controller: fires CONVST on each period tick,
// waits for the busy pulse, then reads CH_PER_CHIP channels from each of
// NUM_CHIPS chips over a shared bus and streams them out with valid/ready.
// Optional: define DAQ_FRSTDATA_CHECK_EN to add the sticky frst_err_o check
// of the chips' first-channel flag.
import platypus_pkg::*;

module daq_scan_ctrl #(
    parameter int NUM_CHIPS    = NUM_CHIPS_DEF,
    parameter int CH_PER_CHIP  = CH_PER_CHIP_DEF,
    parameter int RD_CYC       = RD_CYC_DEF,
    parameter int CONV_LOW_CYC = CONV_LOW_CYC_DEF,
    parameter int BUSY_TO      = BUSY_TO_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic [15:0]          period_i,
    input  logic [2:0]           os_sel_i,
    output logic                 daq_conv_clk_o,
    output logic                 daq_rd_o,
    output logic [NUM_CHIPS-1:0] daq_cs_o,
    input  logic [15:0]          daq_db_i,
    input  logic                 daq_busy_i,
    input  logic                 daq_frstdata_i,
    output logic [2:0]           daq_os_sel_o,
    output logic [15:0]          smp_data_o,
    output logic [7:0]           smp_tag_o,
    output logic                 smp_valid_o,
    input  logic                 smp_ready_i,
    output logic                 overrun_o,
`ifdef DAQ_FRSTDATA_CHECK_EN
    output logic                 frst_err_o,
`endif
    output logic                 busy_to_o
);

    localparam logic [15:0] CONV_LAST = 16'(CONV_LOW_CYC - 1);
    localparam logic [15:0] RD_LAST   = 16'(RD_CYC - 1);
    localparam logic [15:0] TO_LAST   = 16'(BUSY_TO);
    localparam logic [3:0]  CHIP_LAST = 4'(NUM_CHIPS - 1);
    localparam logic [3:0]  CH_LAST   = 4'(CH_PER_CHIP - 1);

    state_e      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;       // phase / timeout counter, per state
    logic [3:0]  chip_q, chip_d;
    logic [3:0]  ch_q, ch_d;
    logic        gap_q, gap_d;       // RD_HI used as chip-to-chip CS gap
    logic [2:0]  os_sel_q, os_sel_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  tag_q, tag_d;
    logic        overrun_q, overrun_d;
    logic        busy_to_q, busy_to_d;
    logic        frst_err_q, frst_err_d;
    logic        tick;

    daq_period_tick u_tick (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    // Scan sequencing, sample capture and sticky status.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + 16'd1;
        chip_d     = chip_q;
        ch_d       = ch_q;
        gap_d      = gap_q;
        os_sel_d   = os_sel_q;
        data_d     = data_q;
        tag_d      = tag_q;
        busy_to_d  = busy_to_q;
        frst_err_d = frst_err_q;
        overrun_d  = overrun_q | (tick && state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                cyc_d = 16'd0;
                if (tick) begin
                    state_d  = ST_CONV;
                    os_sel_d = os_sel_i;
                end
            end
            ST_CONV: if (cyc_q == CONV_LAST) begin
                state_d = ST_WAIT_BH;
                cyc_d   = 16'd0;
            end
            ST_WAIT_BH, ST_WAIT_BL: begin
                if (daq_busy_i == (state_q == ST_WAIT_BH)) begin
                    state_d = (state_q == ST_WAIT_BH) ? ST_WAIT_BL : ST_RD_LO;
                    cyc_d   = 16'd0;
                    chip_d  = 4'd0;
                    ch_d    = 4'd0;
                    gap_d   = 1'b0;
                end else if (cyc_q == TO_LAST) begin
                    state_d   = ST_IDLE;
                    busy_to_d = 1'b1;
                end
            end
            ST_RD_LO: if (cyc_q == RD_LAST) begin
                state_d = ST_RD_HI;
                cyc_d   = 16'd0;
                data_d  = daq_db_i;
                tag_d   = {chip_q, ch_q};
                if (daq_frstdata_i != (ch_q == 4'd0)) frst_err_d = 1'b1;
            end
            ST_RD_HI: if (cyc_q == RD_LAST) begin
                state_d = gap_q ? ST_RD_LO : ST_PUSH;
                cyc_d   = 16'd0;
                gap_d   = 1'b0;
            end
            ST_PUSH: begin
                cyc_d = 16'd0;
                if (smp_ready_i) begin
                    if (ch_q != CH_LAST) begin
                        ch_d    = ch_q + 4'd1;
                        state_d = ST_RD_LO;
                    end else if (chip_q != CHIP_LAST) begin
                        ch_d    = 4'd0;
                        chip_d  = chip_q + 4'd1;
                        gap_d   = 1'b1;
                        state_d = ST_RD_HI;
                    end else begin
                        ch_d    = 4'd0;
                        chip_d  = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 16'd0;
            chip_q     <= 4'd0;
            ch_q       <= 4'd0;
            gap_q      <= 1'b0;
            os_sel_q   <= 3'd0;
            data_q     <= 16'd0;
            tag_q      <= 8'd0;
            overrun_q  <= 1'b0;
            busy_to_q  <= 1'b0;
            frst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            chip_q     <= chip_d;
            ch_q       <= ch_d;
            gap_q      <= gap_d;
            os_sel_q   <= os_sel_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            overrun_q  <= overrun_d;
            busy_to_q  <= busy_to_d;
            frst_err_q <= frst_err_d;
        end
    end

    // ADC strobes are pure decodes of the registered state.
    always_comb begin
        daq_cs_o = '1;
        if ((state_q == ST_RD_LO || state_q == ST_RD_HI || state_q == ST_PUSH) && !gap_q)
            daq_cs_o = ~(NUM_CHIPS'(1) << chip_q);
    end

    assign daq_conv_clk_o = (state_q != ST_CONV);
    assign daq_rd_o       = (state_q != ST_RD_LO);
    assign daq_os_sel_o   = os_sel_q;
    assign smp_valid_o    = (state_q == ST_PUSH);
    assign smp_data_o     = data_q;
    assign smp_tag_o      = tag_q;
    assign overrun_o      = overrun_q;
    assign busy_to_o      = busy_to_q;

`ifdef DAQ_FRSTDATA_CHECK_EN
    assign frst_err_o = frst_err_q;
`else
    logic unused_frst;
    assign unused_frst = frst_err_q;
`endif

endmodule
